// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_master_arbiter_pkg;

    // Number of requesters sharing the single APB master port.
    localparam int NB_REQ = 2;

    // Transfer phases of the APB master; one transfer in flight at a time.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of the wait-state counter: enough to hold timeoutCycles, never below one bit.
    function automatic int waitCntWidth(input int timeoutCycles);
        int w;
        w = $clog2(timeoutCycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin decision: a lone requester always wins, and on a tie
// the requester that was not served last gets the grant.
module apb_rr_arb
    import apb_master_arbiter_pkg::*;
(
    input  logic [NB_REQ-1:0] req_i,
    input  logic              lastOwner_i,
    output logic [NB_REQ-1:0] gnt_o
);

    // Pick the one-hot winner from the current requests and the last owner.
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = lastOwner_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two requesters share one APB master port. A request is granted in IDLE,
// driven through SETUP and ACCESS, and its completion (data plus error) is
// returned to the owner as a one-cycle rvalid pulse. A wait-state counter
// aborts transfers whose slave never raises pready.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    HCLK,
    input  logic                                    HRESETn,
    input  logic [NB_REQ-1:0]                       req_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ-1:0]                       we_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]                       gnt_o,
    output logic [NB_REQ-1:0]                       rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]               rdata_o,
    output logic                                    err_o,
    output logic [APB_ADDR_WIDTH-1:0]               paddr,
    output logic [APB_DATA_WIDTH-1:0]               pwdata,
    output logic                                    pwrite,
    output logic                                    psel,
    output logic                                    penable,
    input  logic [APB_DATA_WIDTH-1:0]               prdata,
    input  logic                                    pready,
    input  logic                                    pslverr
);

    localparam int WAIT_W = waitCntWidth(TIMEOUT_CYCLES);
    // Counter value seen in the last ACCESS cycle allowed before the abort.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    apb_state_e                 state_q;
    logic [WAIT_W-1:0]          waitCnt_q;
    logic [WAIT_W-1:0]          waitCnt_d;
    logic                       lastOwner_q;
    logic [NB_REQ-1:0]          owner_q;
    logic [NB_REQ-1:0]          rvalid_q;
    logic [APB_ADDR_WIDTH-1:0]  paddr_q;
    logic [APB_DATA_WIDTH-1:0]  pwdata_q;
    logic                       pwrite_q;
    logic                       psel_q;
    logic                       penable_q;
    logic [APB_DATA_WIDTH-1:0]  rdata_q;
    logic                       err_q;

    logic [NB_REQ-1:0]          arbGnt;
    logic [NB_REQ-1:0]          gnt;
    logic                       winIdx;
    logic                       timeoutHit;

    apb_rr_arb uRrArb (
        .req_i       (req_i),
        .lastOwner_i (lastOwner_q),
        .gnt_o       (arbGnt)
    );

    // Grants are only offered while idle and never while reset is held.
    always_comb begin
        gnt = '0;
        if (HRESETn && (state_q == IDLE)) begin
            gnt = arbGnt;
        end
    end

    assign winIdx = gnt[1];

    // Wait counter: cleared on the way into ACCESS, counts stalled ACCESS cycles, saturates.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_q == SETUP) begin
            waitCnt_d = '0;
        end else if ((state_q == ACCESS) && !pready && (waitCnt_q != WAIT_MAX)) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    // Abort when this stalled ACCESS cycle is the one that brings the counter to the limit.
    always_comb begin
        timeoutHit = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !pready && (waitCnt_q == WAIT_LAST)) begin
            timeoutHit = 1'b1;
        end
    end

    // Transfer FSM with all APB and completion outputs registered.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            lastOwner_q <= 1'b1;
            owner_q     <= '0;
            rvalid_q    <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rvalid_q  <= '0;
            waitCnt_q <= waitCnt_d;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        paddr_q     <= addr_i[winIdx];
                        pwdata_q    <= wdata_i[winIdx];
                        pwrite_q    <= we_i[winIdx];
                        owner_q     <= gnt;
                        lastOwner_q <= winIdx;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rdata_q   <= prdata;
                        err_q     <= pslverr;
                        rvalid_q  <= owner_q;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (timeoutHit) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        rvalid_q  <= owner_q;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pwrite   = pwrite_q;
    assign psel     = psel_q;
    assign penable  = penable_q;

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32, width of paddr and of each requester address.
REQ-002 Parameter APB_DATA_WIDTH, default 32, width of pwdata, prdata and requester data.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum number of ACCESS cycles without pready; 0 disables the timeout.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-006 HRESETn  input  1  synchronous, active-low reset.
REQ-007 req_i  input  [1:0]  per-requester transfer request, held until granted.
REQ-008 addr_i  input  [1:0][APB_ADDR_WIDTH-1:0]  per-requester address.
REQ-009 we_i  input  [1:0]  per-requester write enable (1 = write).
REQ-010 wdata_i  input  [1:0][APB_DATA_WIDTH-1:0]  per-requester write data.
REQ-011 gnt_o  output  [1:0]  one-cycle grant; request fields are captured in this cycle.
REQ-012 rvalid_o  output  [1:0]  one-cycle completion pulse to the granted requester.
REQ-013 rdata_o  output  APB_DATA_WIDTH  read data, shared by both requesters and qualified by rvalid_o.
REQ-014 err_o  output  1  completion error (pslverr or timeout), qualified by rvalid_o.
REQ-015 paddr  output  APB_ADDR_WIDTH  APB master address.
REQ-016 pwdata  output  APB_DATA_WIDTH  APB master write data.
REQ-017 pwrite  output  1  APB master write strobe.
REQ-018 psel  output  1  APB master select.
REQ-019 penable  output  1  APB master enable.
REQ-020 prdata  input  APB_DATA_WIDTH  APB master read data.
REQ-021 pready  input  1  APB master ready.
REQ-022 pslverr  input  1  APB master slave error.

Function
REQ-023 FSM states are IDLE, SETUP and ACCESS; there is exactly one transfer in flight at a time.
REQ-024 In IDLE, if any req_i bit is set, gnt_o for the winner is asserted combinationally in that cycle, the winner's addr/we/wdata are registered into paddr/pwrite/pwdata, and the FSM moves to SETUP.
REQ-025 Arbitration is two-way round robin: a lone requester always wins; if both request, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-026 In SETUP, psel=1 and penable=0; the next cycle is always ACCESS.
REQ-027 In ACCESS, psel=1 and penable=1; the FSM stays in ACCESS while pready=0.
REQ-028 In ACCESS with pready=1, prdata and pslverr are registered into rdata_o and err_o, the FSM moves to IDLE, and rvalid_o of the owner pulses for one cycle in the following cycle.
REQ-029 rdata_o is registered for writes too; its value on a write completion is don't-care.
REQ-030 paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE.
REQ-031 psel and penable are 0 in IDLE.
REQ-032 Zero-wait-state latency: gnt in cycle N, SETUP in N+1, ACCESS with pready in N+2, rvalid in N+3.
REQ-033 A new grant is allowed in the same cycle as rvalid (N+3), which gives one transfer per 3 cycles back to back.
REQ-034 A wait counter is cleared on entry to ACCESS and increments for each ACCESS cycle with pready=0.
REQ-035 If TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES, the transfer is aborted: rdata_o=0, err_o=1, FSM moves to IDLE, and rvalid_o pulses in the next cycle.
REQ-036 The wait counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit, and it saturates without wrapping.
REQ-037 When pready=1 arrives in the same cycle the timeout is reached, pready wins and a normal completion is reported.
REQ-038 req_i bits that drop before being granted are simply ignored; there is no request queueing.
REQ-039 gnt_o is never asserted outside IDLE, and at most one gnt_o or rvalid_o bit is high in any cycle.

Reset
REQ-040 While HRESETn=0 at a clock edge: FSM=IDLE; psel, penable, pwrite, paddr, pwdata, rdata_o, err_o, rvalid_o and the wait counter are 0; the round-robin pointer selects requester 0 for the next tie.
REQ-041 Reset asserted mid-transfer drops psel and penable in the next cycle, and no rvalid_o is issued for the aborted transfer.
REQ-042 gnt_o is 0 during reset regardless of req_i.

Structure
REQ-043 Package apb_master_arbiter_pkg holds the FSM state enum (IDLE, SETUP, ACCESS) and the constant NB_REQ=2.
REQ-044 The round-robin decision is a separate sub-module, apb_rr_arb, taking req and the last-owner pointer as inputs and producing a one-hot grant; everything else lives in apb_master_arbiter.

Verification
REQ-045 Requester 0 reads 0x1A10_2000 with zero-wait pready and prdata=0xDEAD_BEEF: gnt_o=01 at N, psel at N+1, penable at N+2, rvalid_o=01 at N+3 with rdata_o=0xDEAD_BEEF and err_o=0.
REQ-046 Both requesters request continuously from reset: grants alternate 01,10,01,10 on cycles N, N+3, N+6, N+9.
REQ-047 Write by requester 1 to 0x1A10_5004 with 2 wait states and pslverr=1 on completion: paddr, pwdata and pwrite are stable over 3 ACCESS cycles, then rvalid_o=10 and err_o=1.
REQ-048 TIMEOUT_CYCLES=4 with pready held at 0: exactly 4 ACCESS cycles, psel drops, rvalid pulses with err_o=1 and rdata_o=0; a repeat run with pready=1 on the 4th cycle completes normally with err_o=0.
REQ-049 HRESETn driven to 0 during ACCESS: psel=0 and penable=0 in the next cycle, no rvalid_o, and the first tie after reset is granted to requester 0.
